// File: rtl/mod_reduce_pkg.sv
// Shared constants and types for the bit-serial 512-to-256-bit modular reducer.
package mod_reduce_pkg;

  localparam int MR_WIDTH      = 256;
  localparam int MR_PROD_WIDTH = 2 * MR_WIDTH;
  localparam int MR_CNT_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } mr_state_e;

endpackage : mod_reduce_pkg

// File: rtl/mod_reduce_if.sv
// Request/response bundle between the multiplier side and the modular reducer.
interface mod_reduce_if;
  import mod_reduce_pkg::*;

  logic                     update;
  logic [MR_PROD_WIDTH-1:0] product;
  logic [MR_WIDTH-1:0]      modulus;
  logic [MR_WIDTH-1:0]      result;
  logic                     done;
  logic                     err;

  modport master (
    output update, product, modulus,
    input  result, done, err
  );

  modport slave (
    input  update, product, modulus,
    output result, done, err
  );

endinterface : mod_reduce_if

// File: rtl/mod_reduce_step.sv
// One restoring-reduction step: shift in a dividend bit, then subtract n if the
// 257-bit partial remainder reaches it.
module mod_reduce_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] t;
  logic           ge;

  assign t  = {r_i, bit_i};
  assign ge = (t >= {1'b0, n_i});

  // The true difference is below n, so the low WIDTH bits of a WIDTH-bit
  // subtraction are exact and the carry-out bit can be dropped.
  assign r_o = ge ? (t[WIDTH-1:0] - n_i) : t[WIDTH-1:0];

endmodule : mod_reduce_step

// File: rtl/mod_reduce_512.sv
// Sequential product mod n reducer, one product bit per clock.
// Define MODRED_PRELOAD_EN to skip the upper-half iterations when product[511:256] < n.
module mod_reduce_512
  import mod_reduce_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mod_reduce_if.slave bus_if
);

  mr_state_e                state_q, state_d;
  logic                     update_q;
  logic [MR_PROD_WIDTH-1:0] shift_q, shift_d;
  logic [MR_WIDTH-1:0]      n_q, n_d;
  logic [MR_WIDTH-1:0]      r_q, r_d;
  logic [MR_WIDTH-1:0]      result_q, result_d;
  logic [MR_CNT_W-1:0]      cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     zero_pend_q, zero_pend_d;

  logic                     capture;
  logic                     mod_zero;
  logic                     preload;
  logic                     last_step;
  logic [MR_WIDTH-1:0]      prod_hi, prod_lo;
  logic [MR_WIDTH-1:0]      r_step;

  assign capture   = bus_if.update & ~update_q;
  assign mod_zero  = (bus_if.modulus == '0);
  assign prod_hi   = bus_if.product[MR_PROD_WIDTH-1:MR_WIDTH];
  assign prod_lo   = bus_if.product[MR_WIDTH-1:0];
  assign last_step = (cnt_q == MR_CNT_W'(1));

`ifdef MODRED_PRELOAD_EN
  // Upper half already reduced: start from it and only walk the lower half.
  assign preload = (prod_hi < bus_if.modulus);
`else
  assign preload = 1'b0;
`endif

  mod_reduce_step #(
    .WIDTH (MR_WIDTH)
  ) u_step (
    .r_i   (r_q),
    .bit_i (shift_q[MR_PROD_WIDTH-1]),
    .n_i   (n_q),
    .r_o   (r_step)
  );

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = mod_zero ? FIN : RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = last_step ? FIN : RUN;
        FIN:     state_d = FIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next-state logic
  always_comb begin
    // NOTE: every target gets a hold default first, so no path infers a latch.
    shift_d     = shift_q;
    n_d         = n_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    done_d      = done_q;
    err_d       = err_q;
    zero_pend_d = zero_pend_q;

    if (capture) begin
      n_d         = bus_if.modulus;
      done_d      = 1'b0;
      err_d       = 1'b0;
      zero_pend_d = mod_zero;
      if (preload) begin
        r_d     = prod_hi;
        shift_d = {prod_lo, {MR_WIDTH{1'b0}}};
        cnt_d   = MR_CNT_W'(MR_WIDTH);
      end else begin
        r_d     = '0;
        shift_d = bus_if.product;
        cnt_d   = MR_CNT_W'(MR_PROD_WIDTH);
      end
    end else begin
      unique case (state_q)
        RUN: begin
          r_d     = r_step;
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - MR_CNT_W'(1);
          if (last_step) begin
            result_d = r_step;
            done_d   = 1'b1;
          end
        end
        FIN: begin
          // A zero modulus reports one edge after capture, then holds.
          if (zero_pend_q) begin
            result_d    = '0;
            done_d      = 1'b1;
            err_d       = 1'b1;
            zero_pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_q    <= 1'b0;
      shift_q     <= '0;
      n_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      zero_pend_q <= 1'b0;
    end else begin
      update_q    <= bus_if.update;
      shift_q     <= shift_d;
      n_q         <= n_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
      zero_pend_q <= zero_pend_d;
    end
  end

  assign bus_if.result = result_q;
  assign bus_if.done   = done_q;
  assign bus_if.err    = err_q;

endmodule : mod_reduce_512

// File: tb/tb_mod_reduce_512.sv
// Self-checking bench for mod_reduce_512: vector table plus abort/reset sequences,
// expectations from a behavioural % model and a latency model.
module tb_mod_reduce_512;
  import mod_reduce_pkg::*;

  typedef struct {
    logic [MR_PROD_WIDTH-1:0] product;
    logic [MR_WIDTH-1:0]      modulus;
    logic [MR_WIDTH-1:0]      exp_result;
    logic                     exp_err;
  } vec_t;

  typedef struct {
    logic [MR_WIDTH-1:0] result;
    logic                err;
    int                  lat;
  } exp_t;

  localparam int NVEC    = 9;
  localparam int TIMEOUT = 600;

  logic clk;
  logic rst;
  mod_reduce_if bus_if ();

  mod_reduce_512 dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_applied = 0;
  int   n_fail    = 0;
  vec_t vecs [NVEC];
  exp_t exp_q [$];

  task automatic check(input string name, input logic [MR_WIDTH-1:0] act,
                       input logic [MR_WIDTH-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MR_PROD_WIDTH-1:0] rand512();
    logic [MR_PROD_WIDTH-1:0] v;
    for (int i = 0; i < MR_PROD_WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [MR_WIDTH-1:0] model_mod(input logic [MR_PROD_WIDTH-1:0] p,
                                                    input logic [MR_WIDTH-1:0] m);
    logic [MR_PROD_WIDTH-1:0] r;
    if (m == '0) return '0;
    r = p % {{MR_WIDTH{1'b0}}, m};
    return r[MR_WIDTH-1:0];
  endfunction

  function automatic int model_lat(input logic [MR_PROD_WIDTH-1:0] p,
                                   input logic [MR_WIDTH-1:0] m);
    if (m == '0) return 1;
`ifdef MODRED_PRELOAD_EN
    if (p[MR_PROD_WIDTH-1:MR_WIDTH] < m) return MR_WIDTH;
`endif
    return MR_PROD_WIDTH;
  endfunction

  // Drive a fresh rising edge on update; returns just after the capture edge.
  task automatic start_op(input logic [MR_PROD_WIDTH-1:0] p, input logic [MR_WIDTH-1:0] m);
    @(negedge clk);
    bus_if.update = 1'b0;
    @(negedge clk);
    bus_if.product = p;
    bus_if.modulus = m;
    bus_if.update  = 1'b1;
    @(posedge clk);
    #1;
    check("done_after_capture", MR_WIDTH'(bus_if.done), MR_WIDTH'(0));
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, MR_WIDTH'(0), MR_WIDTH'(1));
    end else begin
      check({tag, "_latency"}, MR_WIDTH'(lat), MR_WIDTH'(e.lat));
      check({tag, "_result"}, bus_if.result, e.result);
      check({tag, "_err"}, MR_WIDTH'(bus_if.err), MR_WIDTH'(e.err));
    end
  endtask

  task automatic push_exp(input logic [MR_PROD_WIDTH-1:0] p, input logic [MR_WIDTH-1:0] m,
                          input logic [MR_WIDTH-1:0] r, input logic er);
    exp_t e;
    e.result = r;
    e.err    = er;
    e.lat    = model_lat(p, m);
    exp_q.push_back(e);
  endtask

  initial begin
    logic [MR_PROD_WIDTH-1:0] p;
    logic [MR_WIDTH-1:0]      m;
    logic [MR_WIDTH-1:0]      held;

    // Directed vectors with hand-derived results.
    vecs[0] = '{MR_PROD_WIDTH'(1000), MR_WIDTH'(7), MR_WIDTH'(6), 1'b0};
    vecs[1] = '{{MR_PROD_WIDTH{1'b1}}, {MR_WIDTH{1'b1}}, MR_WIDTH'(0), 1'b0};
    vecs[2] = '{MR_PROD_WIDTH'(123), MR_WIDTH'(0), MR_WIDTH'(0), 1'b1};
    vecs[3] = '{MR_PROD_WIDTH'(5), MR_WIDTH'(9), MR_WIDTH'(5), 1'b0};
    m = '0;
    m[MR_WIDTH-1] = 1'b1;
    vecs[4] = '{{MR_WIDTH'(3), MR_WIDTH'(4)}, m, MR_WIDTH'(4), 1'b0};
    // Random vectors checked against the % model; the odd ones keep the upper half below n.
    for (int i = 5; i < NVEC; i++) begin
      p = rand512();
      m = rand512() | MR_WIDTH'(1);
      if (i % 2 == 1) begin
        m[MR_WIDTH-1]      = 1'b1;
        p[MR_PROD_WIDTH-1] = 1'b0;
      end
      vecs[i] = '{p, m, model_mod(p, m), 1'b0};
    end

    bus_if.update  = 1'b0;
    bus_if.product = '0;
    bus_if.modulus = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus_if.result, MR_WIDTH'(0));
    check("reset_done", MR_WIDTH'(bus_if.done), MR_WIDTH'(0));
    check("reset_err", MR_WIDTH'(bus_if.err), MR_WIDTH'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      push_exp(vecs[i].product, vecs[i].modulus, vecs[i].exp_result, vecs[i].exp_err);
      start_op(vecs[i].product, vecs[i].modulus);
      finish_op($sformatf("vec%0d", i));
      if (i == 0) begin
        held = bus_if.result;
        repeat (3) @(posedge clk);
        #1;
        check("fin_hold_done", MR_WIDTH'(bus_if.done), MR_WIDTH'(1));
        check("fin_hold_result", bus_if.result, MR_WIDTH'(6));
        check("fin_hold_stable", bus_if.result, held);
      end
    end

    // Abort: re-trigger at cycle 100 of an operation; only the second completes.
    start_op(MR_PROD_WIDTH'(1000), MR_WIDTH'(7));
    repeat (99) @(posedge clk);
    #1;
    check("abort_no_done", MR_WIDTH'(bus_if.done), MR_WIDTH'(0));
    push_exp(MR_PROD_WIDTH'(20), MR_WIDTH'(6), MR_WIDTH'(2), 1'b0);
    start_op(MR_PROD_WIDTH'(20), MR_WIDTH'(6));
    finish_op("retrigger");

    // Reset mid-operation with update held high through release.
    start_op(MR_PROD_WIDTH'(1000), MR_WIDTH'(7));
    repeat (50) @(posedge clk);
    @(negedge clk);
    bus_if.product = MR_PROD_WIDTH'(5);
    bus_if.modulus = MR_WIDTH'(9);
    rst = 1'b1;
    #1;
    check("midrst_result", bus_if.result, MR_WIDTH'(0));
    check("midrst_done", MR_WIDTH'(bus_if.done), MR_WIDTH'(0));
    check("midrst_err", MR_WIDTH'(bus_if.err), MR_WIDTH'(0));
    @(negedge clk);
    rst = 1'b0;
    push_exp(MR_PROD_WIDTH'(5), MR_WIDTH'(9), MR_WIDTH'(5), 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_capture_done", MR_WIDTH'(bus_if.done), MR_WIDTH'(0));
    finish_op("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule : tb_mod_reduce_512
